// File: rtl/io_uart_tx_pkg.sv
// Shared IO map constants and TX FSM types for the IO UART/LED responder.
// The same bit positions are used by the core-side software headers and the SOC.
package io_uart_tx_pkg;

  // One-hot word-select bits within IO_mem_addr[15:2]
  localparam int IO_LEDS_BIT      = 0;
  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_CNTL_BIT = 2;

  // Bit positions inside the UART status word
  localparam int UART_ACTIVE_BIT = 8;
  localparam int UART_FULL_BIT   = 9;
  localparam int UART_OVF_BIT    = 10;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic int calcDiv(input int clkFreqHz, input int baud);
    return clkFreqHz / baud;
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// Core-side IO bus: the core drives address/data/strobe, the device returns read data.
interface io_uart_tx_if;

  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (
    output IO_mem_addr,
    output IO_mem_wdata,
    output IO_mem_wr,
    input  IO_mem_rdata
  );

  modport slave (
    input  IO_mem_addr,
    input  IO_mem_wdata,
    input  IO_mem_wr,
    output IO_mem_rdata
  );

endinterface

// File: rtl/io_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full succeeds only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_rdPtr];
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // Storage is left unreset so it can map onto plain RAM
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// IO-bus responder with an LED register and a FIFO-backed 8N1 UART transmitter.
// Reads are combinational from the address so the core samples them in the same cycle.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  io_uart_tx_if.slave      bus,
  output logic [5:0]       LEDS,
  output logic             uart_txd
);

  localparam int DIV = calcDiv(CLK_FREQ_HZ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [13:0]   w_sel;
  logic          w_wrLeds;
  logic          w_wrDat;
  logic          w_wrCntl;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifoDout;
  logic [CW-1:0] w_count;
  logic          w_txActive;
  logic          w_bcntDone;
  logic          w_unused;

  logic          r_ovf;
  tx_state_e     r_state;
  logic [BW-1:0] r_bcnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;

  tx_state_e     w_nextState;
  logic [BW-1:0] w_nextBcnt;
  logic [2:0]    w_nextBit;
  logic [7:0]    w_nextShift;
  logic          w_nextTxd;

  assign w_sel    = bus.IO_mem_addr[15:2];
  assign w_wrLeds = bus.IO_mem_wr && w_sel[IO_LEDS_BIT];
  assign w_wrDat  = bus.IO_mem_wr && w_sel[IO_UART_DAT_BIT];
  assign w_wrCntl = bus.IO_mem_wr && w_sel[IO_UART_CNTL_BIT];
  assign w_unused = &{1'b0, bus.IO_mem_addr[31:16], bus.IO_mem_addr[1:0],
                      w_sel[13:3], bus.IO_mem_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wrDat),
    .pop   (w_pop),
    .din   (bus.IO_mem_wdata[7:0]),
    .dout  (w_fifoDout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      LEDS <= '0;
    end else if (w_wrLeds) begin
      LEDS <= bus.IO_mem_wdata[5:0];
    end
  end

  // A drop in the same store that also clears the flag still reports overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_wrDat && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_wrCntl) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_txActive = !w_empty || (r_state != TX_IDLE);

  always_comb begin
    bus.IO_mem_rdata = '0;
    if (w_sel[IO_LEDS_BIT]) begin
      bus.IO_mem_rdata = bus.IO_mem_rdata | {26'b0, LEDS};
    end
    if (w_sel[IO_UART_DAT_BIT]) begin
      bus.IO_mem_rdata[UART_OVF_BIT]    = bus.IO_mem_rdata[UART_OVF_BIT] | r_ovf;
      bus.IO_mem_rdata[UART_FULL_BIT]   = bus.IO_mem_rdata[UART_FULL_BIT] | w_full;
      bus.IO_mem_rdata[UART_ACTIVE_BIT] = bus.IO_mem_rdata[UART_ACTIVE_BIT] | w_txActive;
    end
    if (w_sel[IO_UART_CNTL_BIT]) begin
      bus.IO_mem_rdata = bus.IO_mem_rdata | 32'(w_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= TX_IDLE;
      r_bcnt   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      uart_txd <= 1'b1;
    end else begin
      r_state  <= w_nextState;
      r_bcnt   <= w_nextBcnt;
      r_bitIdx <= w_nextBit;
      r_shift  <= w_nextShift;
      uart_txd <= w_nextTxd;
    end
  end

  assign w_bcntDone = (r_bcnt == BW'(DIV - 1));

  // STOP chains straight into START when another byte is queued, so frames abut
  always_comb begin
    w_nextState = r_state;
    w_nextBcnt  = r_bcnt;
    w_nextBit   = r_bitIdx;
    w_nextShift = r_shift;
    w_nextTxd   = uart_txd;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_nextTxd = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nextShift = w_fifoDout;
          w_nextState = TX_START;
          w_nextTxd   = 1'b0;
          w_nextBcnt  = '0;
        end
      end
      TX_START: begin
        if (w_bcntDone) begin
          w_nextState = TX_DATA;
          w_nextTxd   = r_shift[0];
          w_nextBcnt  = '0;
          w_nextBit   = '0;
        end else begin
          w_nextBcnt = r_bcnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (w_bcntDone) begin
          w_nextBcnt = '0;
          if (r_bitIdx == 3'd7) begin
            w_nextState = TX_STOP;
            w_nextTxd   = 1'b1;
            w_nextBit   = '0;
          end else begin
            w_nextBit   = r_bitIdx + 1'b1;
            w_nextShift = {1'b0, r_shift[7:1]};
            w_nextTxd   = r_shift[1];
          end
        end else begin
          w_nextBcnt = r_bcnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_bcntDone) begin
          w_nextBcnt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nextShift = w_fifoDout;
            w_nextState = TX_START;
            w_nextTxd   = 1'b0;
          end else begin
            w_nextState = TX_IDLE;
            w_nextTxd   = 1'b1;
          end
        end else begin
          w_nextBcnt = r_bcnt + 1'b1;
        end
      end
      default: begin
        w_nextState = TX_IDLE;
        w_nextTxd   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at DIV=4 (40-cycle frames) with a 16-entry FIFO.
// A free-running line monitor decodes frames for the overflow/ordering test.
module tb_io_uart_tx;

  localparam logic [31:0] ADDR_LEDS = 32'h0040_0004;
  localparam logic [31:0] ADDR_DAT  = 32'h0040_0008;
  localparam logic [31:0] ADDR_CNTL = 32'h0040_0010;

  logic       clk;
  logic       reset;
  logic [5:0] leds;
  logic       uartTxd;

  int assertCount = 0;
  int failCount   = 0;
  int rxFrameErr  = 0;
  logic [7:0] rxQ[$];
  logic [7:0] rxByte;

  io_uart_tx_if bus ();

  io_uart_tx #(
    .CLK_FREQ_HZ (100),
    .BAUD        (25),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .LEDS     (leds),
    .uart_txd (uartTxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line monitor: finds a start bit, samples each bit mid-slot, queues the byte
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uartTxd == 1'b0) begin
        repeat (2) @(negedge clk);
        if (uartTxd !== 1'b0) rxFrameErr++;
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          rxByte[b] = uartTxd;
        end
        repeat (4) @(negedge clk);
        if (uartTxd !== 1'b1) rxFrameErr++;
        rxQ.push_back(rxByte);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic wr);
    bus.IO_mem_addr  = addr;
    bus.IO_mem_wdata = data;
    bus.IO_mem_wr    = wr;
  endtask

  task automatic ioWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, data, 1'b1);
    tick();
    applyStimulus(32'h0, 32'h0, 1'b0);
  endtask

  task automatic ioRead(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(addr, 32'h0, 1'b0);
    #1;
    data = bus.IO_mem_rdata;
  endtask

  // Expects the current sample to be cycle 0 of the frame's start bit
  task automatic checkFrame(input logic [7:0] value, input string tag);
    logic [9:0]  frame;
    logic [31:0] rd;
    frame = {1'b1, value, 1'b0};
    for (int i = 0; i < 40; i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), uartTxd, frame[i/4]);
      ioRead(ADDR_DAT, rd);
      checkOutput($sformatf("%s_active%0d", tag, i), rd[8], 1'b1);
      tick();
    end
  endtask

  initial begin
    logic [31:0] rd;
    int          waitCycles;
    int          lowSeen;

    reset = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0);

    // 1. Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("t1Txd", uartTxd, 1'b1);
    checkOutput("t1Leds", leds, 6'h00);
    ioRead(ADDR_LEDS, rd);
    checkOutput("t1RdLeds", rd, 32'h0);
    ioRead(ADDR_DAT, rd);
    checkOutput("t1RdStatus", rd, 32'h0);
    ioRead(ADDR_CNTL, rd);
    checkOutput("t1RdCount", rd, 32'h0);

    // 2. LED path
    applyStimulus(ADDR_LEDS, 32'h0000_002A, 1'b1);
    #1;
    checkOutput("t2LedsBeforeEdge", leds, 6'h00);
    tick();
    applyStimulus(32'h0, 32'h0, 1'b0);
    checkOutput("t2LedsAfterEdge", leds, 6'h2A);
    ioRead(ADDR_LEDS, rd);
    checkOutput("t2RdLeds", rd, 32'h2A);
    ioRead(ADDR_DAT, rd);
    tick();
    checkOutput("t2RdStatus", rd, 32'h0);
    checkOutput("t2LedsAfterRead", leds, 6'h2A);
    applyStimulus(ADDR_LEDS, 32'h0000_0015, 1'b0);
    tick();
    checkOutput("t2LedsNoStrobe", leds, 6'h2A);
    ioRead(32'h0040_000C, rd);
    checkOutput("t2RdOrLedsStatus", rd, 32'h2A);
    ioRead(32'h0040_0000, rd);
    checkOutput("t2RdNoSelect", rd, 32'h0);

    // 3. Single byte with exact latency
    ioWrite(ADDR_DAT, 32'h55);
    ioRead(ADDR_DAT, rd);
    checkOutput("t3ActiveAtE0", rd, 32'h100);
    checkOutput("t3TxdAtE0", uartTxd, 1'b1);
    tick();
    checkFrame(8'h55, "t3");
    ioRead(ADDR_DAT, rd);
    checkOutput("t3StatusAfter", rd, 32'h0);
    checkOutput("t3TxdAfter", uartTxd, 1'b1);

    // 4. Back-to-back frames with no idle gap
    ioWrite(ADDR_DAT, 32'h41);
    ioWrite(ADDR_DAT, 32'h42);
    checkFrame(8'h41, "t4a");
    checkFrame(8'h42, "t4b");
    checkOutput("t4TxdIdle", uartTxd, 1'b1);
    ioRead(ADDR_DAT, rd);
    checkOutput("t4StatusAfter", rd, 32'h0);

    // 5. Overflow: byte 1 is popped on write 2's edge, writes 2..17 fill the FIFO
    rxQ.delete();
    rxFrameErr = 0;
    for (int k = 1; k <= 17; k++) begin
      ioWrite(ADDR_DAT, 32'h60 + k);
    end
    ioRead(ADDR_CNTL, rd);
    checkOutput("t5CountFull", rd, 32'd16);
    ioRead(ADDR_DAT, rd);
    checkOutput("t5StatusFull", rd, 32'h300);
    ioWrite(ADDR_DAT, 32'h60 + 18);
    ioRead(ADDR_DAT, rd);
    checkOutput("t5StatusOvf", rd, 32'h700);
    ioRead(ADDR_CNTL, rd);
    checkOutput("t5CountAfterDrop", rd, 32'd16);
    ioWrite(ADDR_CNTL, 32'hFFFF_FFFF);
    ioRead(ADDR_DAT, rd);
    checkOutput("t5StatusCleared", rd, 32'h300);
    waitCycles = 0;
    while (rxQ.size() < 17 && waitCycles < 1000) begin
      tick();
      waitCycles++;
    end
    checkOutput("t5RxCount", rxQ.size(), 32'd17);
    for (int k = 1; k <= 17; k++) begin
      if (rxQ.size() >= k) begin
        checkOutput($sformatf("t5RxByte%0d", k), rxQ[k-1], 32'h60 + k);
      end
    end
    checkOutput("t5FrameErrors", rxFrameErr, 32'd0);
    repeat (8) tick();
    checkOutput("t5RxNoExtra", rxQ.size(), 32'd17);
    ioRead(ADDR_DAT, rd);
    checkOutput("t5StatusIdle", rd, 32'h0);
    ioRead(ADDR_CNTL, rd);
    checkOutput("t5CountEmpty", rd, 32'h0);

    // 6. Reset mid-frame discards the frame and the queued byte
    ioWrite(ADDR_DAT, 32'hA5);
    ioWrite(ADDR_DAT, 32'h3C);
    checkOutput("t6StartBit", uartTxd, 1'b0);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    checkOutput("t6TxdAfterReset", uartTxd, 1'b1);
    checkOutput("t6LedsAfterReset", leds, 6'h00);
    ioRead(ADDR_CNTL, rd);
    checkOutput("t6CountAfterReset", rd, 32'h0);
    ioRead(ADDR_DAT, rd);
    checkOutput("t6StatusAfterReset", rd, 32'h0);
    reset = 1'b0;
    lowSeen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (uartTxd !== 1'b1) lowSeen++;
    end
    checkOutput("t6NoNewFrame", lowSeen, 32'd0);
    ioRead(ADDR_DAT, rd);
    checkOutput("t6StatusFinal", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped IO responder that sits on the core's IO bus (IO_mem_addr/IO_mem_wdata/IO_mem_wr/IO_mem_rdata) and is the device end of the core's IO load/store path. It provides three registers:
- LED output register.
- UART transmit data port, backed by a byte FIFO.
- UART status/control word.

It serializes queued bytes as 8N1 frames on uart_txd. It replaces the simulation-only character print in the SOC and returns status synchronously for IO loads.

Parameters:
CLK_FREQ_HZ, 27000000, system clock frequency.
BAUD, 115200, line rate. DIV = CLK_FREQ_HZ/BAUD (integer division), evaluated at elaboration; DIV must be >= 2.
FIFO_DEPTH, 16, TX byte FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
IO_mem_addr  input  32  IO byte address from core M stage. Only word address bits [15:2] are decoded.
IO_mem_wdata  input  32  store data.
IO_mem_wr  input  1  one-cycle IO store strobe.
IO_mem_rdata  output  32  read data, combinational from IO_mem_addr.
LEDS  output  6  LED register.
uart_txd  output  1  serial line, idle high, registered.

Behaviour:
- Decode. w = IO_mem_addr[15:2], one-hot select:
  - w[0] = LEDS.
  - w[1] = UART_DAT.
  - w[2] = UART_CNTL.
- Writes occur only when IO_mem_wr = 1; the selected registers update at that edge.
- Several select bits set on a write: every selected register is written.
- Writes to LEDS: LEDS <= IO_mem_wdata[5:0], visible the cycle after the strobe.
- Writes to UART_DAT: push IO_mem_wdata[7:0] into the FIFO.
- Writes to UART_CNTL: clear the sticky overflow flag; data is ignored.
- Read data, combinational with zero latency: the core samples it at the same edge. Result is the OR of all selected sources; 0 if none selected.
  - w[0]: {26'b0, LEDS}.
  - w[1]: status = bit10 overflow, bit9 fifo_full, bit8 tx_active (FIFO non-empty or state != IDLE); all other bits 0.
  - w[2]: {(31-log2 FIFO_DEPTH)'b0, fifo_count}.
- FIFO:
  - Push while full is accepted only if a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
  - Push into an empty FIFO becomes visible to the FSM on the next edge. No same-cycle bypass.
- TX FSM: states IDLE, START, DATA, STOP. Baud counter bcnt counts 0..DIV-1; bit index counts 0..7.
  - IDLE: txd = 1. If the FIFO is non-empty: pop, latch the byte into the shift register, go to START with txd <= 0 and bcnt <= 0.
  - START: hold for DIV cycles, then go to DATA with txd <= shift[0].
  - DATA: each bit held DIV cycles, LSB first, shift right. After bit 7's DIV cycles go to STOP with txd <= 1.
  - STOP: hold DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency: a byte written at edge E0 into an idle, empty block is popped at E1, and txd is 0 from E1. A frame is exactly 10*DIV cycles.
- Reset values:
  - LEDS = 0, uart_txd = 1, IO_mem_rdata sources all 0.
  - FIFO empty (pointers and count 0), overflow = 0.
  - State IDLE, bcnt = 0, bit index = 0, shift register = 0.
- Reset mid-frame: txd is high the cycle after the reset edge. The frame is truncated and the FIFO contents are discarded.
- Reset has priority over a simultaneous IO_mem_wr.

Decomposition:
- Shared include io_map.vh holds:
  - IO_LEDS_BIT = 0, IO_UART_DAT_BIT = 1, IO_UART_CNTL_BIT = 2.
  - Status bit positions: UART_ACTIVE_BIT = 8, UART_FULL_BIT = 9, UART_OVF_BIT = 10.
- The core-side software headers and the SOC use the same include.
- One sub-module: sync_fifo, parameterized width and depth. Ports: push, pop, din, dout, full, empty, count. Synchronous active-high reset.
- The FSM, baud counter and decode stay in io_uart_tx.

Test Plan:
All tests use CLK_FREQ_HZ=100, BAUD=25 (DIV=4, 40-cycle frame) and FIFO_DEPTH=16.
1. Reset check: hold reset 3 cycles, release -> uart_txd=1, LEDS=0; reads of 0x400004, 0x400008 and 0x400010 all return 0.
2. LED path: IO_mem_wr with addr 0x400004, wdata 0x2A -> LEDS=6'h2A next cycle; read 0x400004 returns 0x2A; reading 0x400008 leaves LEDS unchanged.
3. Single byte: write 0x55 to 0x400008 at E0 -> txd 0 from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles. Status bit8 reads 1 from E0 until the end of stop, then 0x000.
4. Back-to-back: write 0x41 and 0x42 on consecutive cycles -> 80 contiguous frame cycles. The start bit of 0x42 follows the stop bit of 0x41 with no idle cycle.
5. Overflow: 18 writes on consecutive cycles -> after write 17, count = 16 and bit9 = 1. Write 18 is dropped: bit10 = 1, count stays 16. A write to 0x400010 clears bit10; all 17 accepted bytes are transmitted in order.
6. Reset mid-frame: assert reset at cycle 15 of a frame -> txd = 1 next cycle, count = 0, status = 0, and no further frame starts.
